// File: rtl/brisc_pkg.sv
// rtl/brisc_pkg.sv - shared core constants plus data cache state and way-write types
package brisc_pkg;
  localparam int XLEN            = 32;
  localparam int BYTE_LEN        = 8;
  localparam int DCACHE_NUM_SETS = 4;
  localparam int DCACHE_NUM_WAYS = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2} dcache_state_e;

  // FILL installs a whole line, STORE merges masked bytes and dirties, CLEAN only clears dirty.
  typedef enum logic [1:0] {WAY_WR_FILL = 2'd0, WAY_WR_STORE = 2'd1, WAY_WR_CLEAN = 2'd2} way_wr_e;

  function automatic int line_offset_bits(input int line_width);
    return $clog2(line_width / BYTE_LEN);
  endfunction
endpackage

// File: rtl/dcache_way_array.sv
// rtl/dcache_way_array.sv - tag/valid/dirty/data storage of one cache way, one write port, async read
module dcache_way_array
  import brisc_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int IDX_W    = 2,
  parameter int TAG_W    = 26,
  parameter int LINE_W   = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  way_wr_e           wr_kind,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [LINE_W-1:0] wr_mask,
  output logic [TAG_W-1:0]  tag   [NUM_SETS],
  output logic              valid [NUM_SETS],
  output logic              dirty [NUM_SETS],
  output logic [LINE_W-1:0] data  [NUM_SETS]
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s] <= 1'b0;
        dirty[s] <= 1'b0;
      end
    end else if (wr_en) begin
      case (wr_kind)
        WAY_WR_FILL: begin
          valid[wr_idx] <= 1'b1;
          dirty[wr_idx] <= 1'b0;
        end
        WAY_WR_STORE: dirty[wr_idx] <= 1'b1;
        WAY_WR_CLEAN: dirty[wr_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

  // Tag and data are only meaningful under valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_kind == WAY_WR_FILL) tag[wr_idx] <= wr_tag;
    if (wr_en && wr_kind != WAY_WR_CLEAN)
      data[wr_idx] <= (data[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
  end

endmodule

// File: rtl/dcache_wb_assoc.sv
// rtl/dcache_wb_assoc.sv - N-way set-associative write-back write-allocate data cache
module dcache_wb_assoc
  import brisc_pkg::*;
#(
  parameter int NUM_SETS         = DCACHE_NUM_SETS,
  parameter int NUM_WAYS         = DCACHE_NUM_WAYS,
  parameter int ADDRESS_WIDTH    = 32,
  parameter int CACHE_LINE_WIDTH = 128
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        store,
  input  logic                        word,
  input  logic [ADDRESS_WIDTH-1:0]    addr,
  input  logic [XLEN-1:0]             data_in,
  output logic                        hit,
  output logic [XLEN-1:0]             data_out,
  output logic                        req_to_arbiter,
  input  logic                        arbiter_grant,
  output logic                        req_store_to_mem,
  output logic [ADDRESS_WIDTH-1:0]    req_addr_to_mem,
  output logic [CACHE_LINE_WIDTH-1:0] req_line_to_mem,
  input  logic [CACHE_LINE_WIDTH-1:0] fill_data_from_mem,
  input  logic                        fill_data_from_mem_valid
);

  localparam int OFF    = line_offset_bits(CACHE_LINE_WIDTH);
  localparam int IDX    = $clog2(NUM_SETS);
  localparam int IDX_W  = (IDX > 0) ? IDX : 1;
  localparam int TAG_W  = ADDRESS_WIDTH - OFF - IDX;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int WSEL_W = OFF - 2;

  dcache_state_e               state;
  logic [IDX_W-1:0]            idx, lat_idx, wr_idx;
  logic [TAG_W-1:0]            tag, lat_tag;
  logic [WAY_W-1:0]            hit_way, victim, lat_way, wr_way;
  logic [WAY_W-1:0]            vptr [NUM_SETS];
  logic [TAG_W-1:0]            way_tag   [NUM_WAYS][NUM_SETS];
  logic                        way_valid [NUM_WAYS][NUM_SETS];
  logic                        way_dirty [NUM_WAYS][NUM_SETS];
  logic [CACHE_LINE_WIDTH-1:0] way_data  [NUM_WAYS][NUM_SETS];
  logic                        match, fill_ok, wr_any;
  logic [WSEL_W-1:0]           wsel;
  logic [1:0]                  bsel;
  logic [XLEN-1:0]             word_val;
  logic [CACHE_LINE_WIDTH-1:0] hit_line, wr_data, wr_mask;
  way_wr_e                     wr_kind;

  assign idx     = IDX_W'((addr >> OFF) & ADDRESS_WIDTH'(NUM_SETS - 1));
  assign tag     = addr[ADDRESS_WIDTH-1 -: TAG_W];
  assign wsel    = addr[OFF-1:2];
  assign bsel    = addr[1:0];
  assign victim  = vptr[idx];
  // A completion pulse without our grant belongs to another requester.
  assign fill_ok = fill_data_from_mem_valid && arbiter_grant;

  function automatic logic [ADDRESS_WIDTH-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                         input logic [IDX_W-1:0] i);
    return (ADDRESS_WIDTH'(t) << (OFF + IDX)) | (ADDRESS_WIDTH'(i) << OFF);
  endfunction

  // Descending scan so the lowest-numbered matching way wins.
  always_comb begin
    match   = 1'b0;
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_valid[w][idx] && way_tag[w][idx] == tag) begin
        match   = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit      = (state == IDLE) && enable && match;
  assign hit_line = way_data[hit_way][idx];

  always_comb begin
    word_val = hit_line[wsel*XLEN +: XLEN];
    data_out = '0;
    if (hit) data_out = word ? word_val : XLEN'(word_val[bsel*BYTE_LEN +: BYTE_LEN]);
  end

  always_comb begin
    wr_any  = 1'b0;
    wr_kind = WAY_WR_FILL;
    wr_way  = lat_way;
    wr_idx  = lat_idx;
    wr_data = fill_data_from_mem;
    wr_mask = '0;
    case (state)
      IDLE: if (hit && store) begin
        wr_any  = 1'b1;
        wr_kind = WAY_WR_STORE;
        wr_way  = hit_way;
        wr_idx  = idx;
        wr_data = word ? {(CACHE_LINE_WIDTH/XLEN){data_in}}
                       : {(CACHE_LINE_WIDTH/BYTE_LEN){data_in[BYTE_LEN-1:0]}};
        wr_mask = word ? (CACHE_LINE_WIDTH'({XLEN{1'b1}}) << (wsel*XLEN))
                       : (CACHE_LINE_WIDTH'({BYTE_LEN{1'b1}}) << (wsel*XLEN + bsel*BYTE_LEN));
      end
      WB: if (fill_ok) begin
        wr_any  = 1'b1;
        wr_kind = WAY_WR_CLEAN;
      end
      FILL: if (fill_ok) begin
        wr_any  = 1'b1;
        wr_mask = '1;
      end
      default: ;
    endcase
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    dcache_way_array #(
      .NUM_SETS(NUM_SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(CACHE_LINE_WIDTH)
    ) u_way (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_any && wr_way == WAY_W'(w)),
      .wr_kind(wr_kind),
      .wr_idx (wr_idx),
      .wr_tag (lat_tag),
      .wr_data(wr_data),
      .wr_mask(wr_mask),
      .tag    (way_tag[w]),
      .valid  (way_valid[w]),
      .dirty  (way_dirty[w]),
      .data   (way_data[w])
    );
  end

  // Index, tag and victim are latched on leaving IDLE; core inputs are not re-read mid-miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      req_to_arbiter   <= 1'b0;
      req_store_to_mem <= 1'b0;
      req_addr_to_mem  <= '0;
      req_line_to_mem  <= '0;
      lat_idx          <= '0;
      lat_tag          <= '0;
      lat_way          <= '0;
      for (int s = 0; s < NUM_SETS; s++) vptr[s] <= '0;
    end else begin
      case (state)
        IDLE: if (enable && !match) begin
          lat_idx        <= idx;
          lat_tag        <= tag;
          lat_way        <= victim;
          req_to_arbiter <= 1'b1;
          if (way_valid[victim][idx] && way_dirty[victim][idx]) begin
            state            <= WB;
            req_store_to_mem <= 1'b1;
            req_addr_to_mem  <= line_addr(way_tag[victim][idx], idx);
            req_line_to_mem  <= way_data[victim][idx];
          end else begin
            state            <= FILL;
            req_store_to_mem <= 1'b0;
            req_addr_to_mem  <= line_addr(tag, idx);
          end
        end
        WB: if (fill_ok) begin
          state            <= FILL;
          req_store_to_mem <= 1'b0;
          req_addr_to_mem  <= line_addr(lat_tag, lat_idx);
        end
        FILL: if (fill_ok) begin
          state          <= IDLE;
          req_to_arbiter <= 1'b0;
          vptr[lat_idx]  <= (NUM_WAYS == 1) ? '0 : lat_way + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wb_assoc.sv
// tb/tb_dcache_wb_assoc.sv - randomized self-checking bench for dcache_wb_assoc against a cache/memory model
module tb_dcache_wb_assoc;
  localparam int LW    = 128;
  localparam int LB    = LW / 8;
  localparam int NSETS = 4;
  localparam int NWAYS = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          enable = 1'b0, store = 1'b0, word = 1'b0;
  logic [31:0]   addr = '0, data_in = '0;
  logic          hit;
  logic [31:0]   data_out;
  logic          req_to_arbiter, req_store_to_mem;
  logic [31:0]   req_addr_to_mem;
  logic [LW-1:0] req_line_to_mem;
  logic          arbiter_grant = 1'b0, fill_valid = 1'b0;
  logic [LW-1:0] fill_data = '0;
  int            compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  dcache_wb_assoc dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .enable                  (enable),
    .store                   (store),
    .word                    (word),
    .addr                    (addr),
    .data_in                 (data_in),
    .hit                     (hit),
    .data_out                (data_out),
    .req_to_arbiter          (req_to_arbiter),
    .arbiter_grant           (arbiter_grant),
    .req_store_to_mem        (req_store_to_mem),
    .req_addr_to_mem         (req_addr_to_mem),
    .req_line_to_mem         (req_line_to_mem),
    .fill_data_from_mem      (fill_data),
    .fill_data_from_mem_valid(fill_valid)
  );

  typedef struct {
    bit            wb;
    logic [31:0]   a;
    logic [LW-1:0] line;
  } txn_t;

  txn_t          exp_q[$];
  logic [7:0]    mem [int unsigned];
  logic [LW-1:0] m_line  [NSETS][NWAYS];
  bit            m_val   [NSETS][NWAYS];
  bit            m_dirty [NSETS][NWAYS];
  int unsigned   m_tag   [NSETS][NWAYS];
  int            m_ptr   [NSETS];

  function automatic logic [LW-1:0] mem_line(input int unsigned base);
    logic [LW-1:0] l;
    for (int b = 0; b < LB; b++) l[b*8 +: 8] = mem.exists(base + b) ? mem[base + b] : 8'(base + b);
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < NWAYS; w++) begin
        m_val[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endtask

  // Predicts memory traffic into exp_q and returns the expected load value.
  task automatic model_access(input bit st, input bit wd, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] rd);
    int s, w, o;
    int unsigned t, base;
    s = int'((a / LB) % NSETS);
    t = a / (LB * NSETS);
    w = -1;
    rd = '0;
    exp_q.delete();
    for (int i = NWAYS - 1; i >= 0; i--) if (m_val[s][i] && m_tag[s][i] == t) w = i;
    if (w < 0) begin
      w = m_ptr[s];
      if (m_val[s][w] && m_dirty[s][w]) begin
        base = m_tag[s][w] * (LB * NSETS) + s * LB;
        exp_q.push_back('{1'b1, base, m_line[s][w]});
        for (int b = 0; b < LB; b++) mem[base + b] = m_line[s][w][b*8 +: 8];
      end
      base = a - (a % LB);
      exp_q.push_back('{1'b0, base, mem_line(base)});
      m_line[s][w]  = mem_line(base);
      m_val[s][w]   = 1'b1;
      m_dirty[s][w] = 1'b0;
      m_tag[s][w]   = t;
      m_ptr[s]      = (w + 1) % NWAYS;
    end
    o = int'(a % LB);
    if (wd) o = o & ~3;
    if (st) begin
      if (wd) m_line[s][w][o*8 +: 32] = d;
      else    m_line[s][w][o*8 +: 8]  = d[7:0];
      m_dirty[s][w] = 1'b1;
    end else begin
      rd = wd ? m_line[s][w][o*8 +: 32] : {24'h0, m_line[s][w][o*8 +: 8]};
    end
  endtask

  // Drives one core access and plays the memory side; dly<0 means random grant delay.
  task automatic do_access(input bit st, input bit wd, input logic [31:0] a, input logic [31:0] d,
                           input int dly, input bit spur,
                           output logic [31:0] rd, output int nwb, output int nfill, output int cyc);
    logic [31:0] exp_rd;
    int          ewb, efill, cnt;
    bit          busy, done;
    txn_t        cur;
    model_access(st, wd, a, d, exp_rd);
    ewb = 0;
    efill = 0;
    foreach (exp_q[i]) if (exp_q[i].wb) ewb++; else efill++;
    nwb = 0; nfill = 0; cyc = 0; cnt = 0; busy = 1'b0; done = 1'b0; rd = '0;
    cur = '{1'b0, 32'h0, '0};
    enable = 1'b1; store = st; word = wd; addr = a; data_in = d;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      fill_valid = 1'b0;
      arbiter_grant = 1'b0;
      if (hit) begin
        done = 1'b1;
        rd = data_out;
        compared++;
        if (req_to_arbiter !== 1'b0) begin
          mismatched++;
          $display("FAIL hit_with_request: req_to_arbiter=%b, want 0", req_to_arbiter);
        end
      end else if (req_to_arbiter) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_request: store=%b addr=%h, want no request", req_store_to_mem, req_addr_to_mem);
            cur = '{req_store_to_mem === 1'b1, req_addr_to_mem, '0};
          end else begin
            cur = exp_q.pop_front();
            if (req_store_to_mem !== cur.wb || req_addr_to_mem !== cur.a) begin
              mismatched++;
              $display("FAIL req_header: got store=%b addr=%h, want store=%b addr=%h",
                       req_store_to_mem, req_addr_to_mem, cur.wb, cur.a);
            end
            if (cur.wb) begin
              compared++;
              if (req_line_to_mem !== cur.line) begin
                mismatched++;
                $display("FAIL wb_line: got %h, want %h", req_line_to_mem, cur.line);
              end
            end
          end
          if (cur.wb) nwb++; else nfill++;
        end else begin
          compared++;
          if (req_addr_to_mem !== cur.a) begin
            mismatched++;
            $display("FAIL req_stable: addr=%h, want %h", req_addr_to_mem, cur.a);
          end
        end
        if (cnt == 0) begin
          arbiter_grant = 1'b1;
          fill_valid = 1'b1;
          fill_data = cur.wb ? {$urandom(), $urandom(), $urandom(), $urandom()} : cur.line;
          busy = 1'b0;
        end else begin
          cnt--;
          if (spur) begin
            fill_valid = 1'b1;
            fill_data = ~cur.line;
          end
        end
      end
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL access_timeout: addr=%h no hit after %0d cycles, want hit", a, cyc);
    end
    compared++;
    if (nwb != ewb || nfill != efill) begin
      mismatched++;
      $display("FAIL txn_count: addr=%h got wb=%0d fill=%0d, want wb=%0d fill=%0d", a, nwb, nfill, ewb, efill);
    end
    if (!st) begin
      compared++;
      if (rd !== exp_rd) begin
        mismatched++;
        $display("FAIL load_data: addr=%h word=%b got %h, want %h", a, wd, rd, exp_rd);
      end
    end
    @(posedge clk);
    #1;
    enable = 1'b0;
    fill_valid = 1'b0;
    arbiter_grant = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    compared++;
    if (hit !== 1'b0 || data_out !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_core_outputs: hit=%b data_out=%h, want 0 0", hit, data_out);
    end
    compared++;
    if (req_to_arbiter !== 1'b0 || req_store_to_mem !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_req_flags: req=%b store=%b, want 0 0", req_to_arbiter, req_store_to_mem);
    end
    compared++;
    if (req_addr_to_mem !== 32'h0 || req_line_to_mem !== '0) begin
      mismatched++;
      $display("FAIL reset_req_payload: addr=%h line=%h, want 0 0", req_addr_to_mem, req_line_to_mem);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_plan();
    logic [31:0] rd;
    int nwb, nf, cyc;
    do_access(1'b0, 1'b1, 32'h104, 32'h0, 3, 1'b0, rd, nwb, nf, cyc);
    compared++;
    if (rd !== 32'h07060504 || nf != 1 || nwb != 0 || cyc != 6) begin
      mismatched++;
      $display("FAIL first_fill: data=%h fills=%0d wbs=%0d cycles=%0d, want 07060504 1 0 6", rd, nf, nwb, cyc);
    end
    do_access(1'b1, 1'b1, 32'h104, 32'hDEADBEEF, 0, 1'b0, rd, nwb, nf, cyc);
    compared++;
    if (nf != 0 || nwb != 0 || cyc != 1) begin
      mismatched++;
      $display("FAIL store_hit: fills=%0d wbs=%0d cycles=%0d, want 0 0 1", nf, nwb, cyc);
    end
    do_access(1'b0, 1'b0, 32'h105, 32'h0, 0, 1'b0, rd, nwb, nf, cyc);
    compared++;
    if (rd !== 32'h000000BE) begin
      mismatched++;
      $display("FAIL byte_load: got %h, want 000000be", rd);
    end
    do_access(1'b0, 1'b1, 32'h108, 32'h0, 0, 1'b0, rd, nwb, nf, cyc);
    compared++;
    if (rd !== 32'h0B0A0908) begin
      mismatched++;
      $display("FAIL word_load: got %h, want 0b0a0908", rd);
    end
    do_access(1'b0, 1'b1, 32'h140, 32'h0, 2, 1'b0, rd, nwb, nf, cyc);
    compared++;
    if (nf != 1 || nwb != 0 || rd !== 32'h43424140) begin
      mismatched++;
      $display("FAIL second_way_fill: fills=%0d wbs=%0d data=%h, want 1 0 43424140", nf, nwb, rd);
    end
    do_access(1'b0, 1'b1, 32'h180, 32'h0, 1, 1'b0, rd, nwb, nf, cyc);
    compared++;
    if (nf != 1 || nwb != 1 || rd !== 32'h83828180) begin
      mismatched++;
      $display("FAIL dirty_evict: fills=%0d wbs=%0d data=%h, want 1 1 83828180", nf, nwb, rd);
    end
    do_access(1'b0, 1'b1, 32'h100, 32'h0, 1, 1'b0, rd, nwb, nf, cyc);
    compared++;
    if (nf != 1 || nwb != 0 || rd !== 32'h03020100) begin
      mismatched++;
      $display("FAIL clean_evict: fills=%0d wbs=%0d data=%h, want 1 0 03020100", nf, nwb, rd);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] rd;
    int nwb, nf, cyc, n;
    enable = 1'b1; store = 1'b0; word = 1'b1; addr = 32'h1C4;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_to_arbiter && n < 20);
    compared++;
    if (req_to_arbiter !== 1'b1 || req_store_to_mem !== 1'b0 || req_addr_to_mem !== 32'h1C0) begin
      mismatched++;
      $display("FAIL mid_fill_request: req=%b store=%b addr=%h, want 1 0 000001c0",
               req_to_arbiter, req_store_to_mem, req_addr_to_mem);
    end
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    compared++;
    if (req_to_arbiter !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_drops_request: req_to_arbiter=%b, want 0", req_to_arbiter);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    do_access(1'b0, 1'b1, 32'h104, 32'h0, 1, 1'b0, rd, nwb, nf, cyc);
    compared++;
    if (nf != 1 || nwb != 0 || rd !== 32'hDEADBEEF) begin
      mismatched++;
      $display("FAIL reload_after_reset: fills=%0d wbs=%0d data=%h, want 1 0 deadbeef", nf, nwb, rd);
    end
  endtask

  task automatic test_spurious_fill();
    logic [31:0] rd;
    int nwb, nf, cyc;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      fill_valid = 1'b1;
      arbiter_grant = (k == 0);
      fill_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      fill_valid = 1'b0;
      arbiter_grant = 1'b0;
      compared++;
      if (req_to_arbiter !== 1'b0) begin
        mismatched++;
        $display("FAIL idle_pulse_request: req_to_arbiter=%b, want 0", req_to_arbiter);
      end
    end
    @(posedge clk);
    #1;
    do_access(1'b0, 1'b1, 32'h104, 32'h0, 0, 1'b0, rd, nwb, nf, cyc);
    compared++;
    if (nf != 0 || nwb != 0 || cyc != 1 || rd !== 32'hDEADBEEF) begin
      mismatched++;
      $display("FAIL idle_pulse_ignored: fills=%0d cycles=%0d data=%h, want 0 1 deadbeef", nf, cyc, rd);
    end
    do_access(1'b0, 1'b1, 32'h2C8, 32'h0, 3, 1'b1, rd, nwb, nf, cyc);
    compared++;
    if (nf != 1 || nwb != 0 || rd !== 32'hCBCAC9C8) begin
      mismatched++;
      $display("FAIL ungranted_pulse_ignored: fills=%0d data=%h, want 1 cbcac9c8", nf, rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a;
    int nwb, nf, cyc;
    bit st, wd, spur;
    for (int i = 0; i < 250; i++) begin
      a    = $urandom_range(0, 5) * 64 + $urandom_range(0, 3) * 16 + $urandom_range(0, 15);
      st   = 1'($urandom_range(0, 1));
      wd   = 1'($urandom_range(0, 1));
      spur = ($urandom_range(0, 3) == 0);
      do_access(st, wd, a, $urandom(), -1, spur, rd, nwb, nf, cyc);
      if (i % 37 == 5) begin
        @(negedge clk);
        fill_valid = 1'b1;
        arbiter_grant = 1'($urandom_range(0, 1));
        fill_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        fill_valid = 1'b0;
        arbiter_grant = 1'b0;
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_reset_mid_fill();
    test_spurious_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dcache_wb_assoc.md
Name: dcache_wb_assoc

Overview:
Parametrised successor to the single-line direct data cache. It is an N-way set-associative, write-back, write-allocate data cache with per-line valid and dirty bits and a per-set round-robin victim pointer. A small FSM serialises dirty-line writeback and line refill through the shared memory arbiter. It sits between the MEM stage (load/store unit) and the arbiter/memory, and it replaces write-through store forwarding.

Parameters:
NUM_SETS, 4, number of sets; power of two, at least 1.
NUM_WAYS, 2, associativity; power of two, at least 1.
ADDRESS_WIDTH, 32, byte-address width.
CACHE_LINE_WIDTH, 128, line width in bits; power of two, at least 2*XLEN.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  request valid from the core; held stable until hit=1.
store  in  1  1 means store, 0 means load.
word  in  1  1 means a 32-bit access, 0 means a byte access.
addr  in  ADDRESS_WIDTH  byte address.
data_in  in  XLEN  store data. Byte stores use [7:0].
hit  out  1  access completes this cycle.
data_out  out  XLEN  load data, valid when hit=1 and store=0.
req_to_arbiter  out  1  memory request, held until fill_data_from_mem_valid.
arbiter_grant  in  1  grant; may arrive any number of cycles after the request.
req_store_to_mem  out  1  1 means line writeback, 0 means line fill.
req_addr_to_mem  out  ADDRESS_WIDTH  line-aligned address; offset bits are 0.
req_line_to_mem  out  CACHE_LINE_WIDTH  victim line data for writeback.
fill_data_from_mem  in  CACHE_LINE_WIDTH  fill line.
fill_data_from_mem_valid  in  1  single-cycle completion pulse for either a fill or a writeback.

Behaviour:
- Address split:
  - OFF = log2(CACHE_LINE_WIDTH/8).
  - IDX = log2(NUM_SETS); if NUM_SETS = 1, IDX = 0.
  - tag = addr[AW-1:OFF+IDX].
  - word select = addr[OFF-1:2]; byte select = addr[1:0].
  - For word accesses addr[1:0] is ignored.
- Storage: flops for tag, valid, dirty and data, per set and way. One victim pointer of log2(NUM_WAYS) bits per set.
- Reset (asynchronous):
  - State = IDLE.
  - All valid, dirty and victim pointers = 0.
  - Outputs hit, req_to_arbiter, req_store_to_mem = 0.
  - data_out, req_addr_to_mem, req_line_to_mem = 0.
- FSM states: IDLE, WB, FILL.
  - IDLE:
    - Lookup is combinational and compares all ways in parallel.
    - On enable and a tag match on a valid way, hit=1 in the same cycle.
    - Load hit: data_out is the selected word, or the selected byte zero-extended.
    - Store hit: at the clock edge, write the word or the single byte and set dirty. No memory traffic.
    - Miss with the victim way (pointer) invalid or clean: go to FILL.
    - Miss with the victim way valid and dirty: go to WB.
    - While enable=0: stay in IDLE with hit=0.
  - WB:
    - req_to_arbiter=1, req_store_to_mem=1.
    - req_addr_to_mem = {victim tag, index, 0}; req_line_to_mem = victim data.
    - On fill_data_from_mem_valid, clear the victim's dirty bit and go to FILL.
  - FILL:
    - req_to_arbiter=1, req_store_to_mem=0, req_addr_to_mem = {tag, index, 0}.
    - On fill_data_from_mem_valid, write the line into the victim way with valid=1 and dirty=0, advance the set's victim pointer modulo NUM_WAYS, and go to IDLE.
    - The retried access hits one cycle later, so miss latency = WB cycles + FILL cycles + 1.
- fill_data_from_mem_valid is ignored in IDLE, and when arbiter_grant=0. This protects against fills destined for another cache.
- hit is never 1 outside IDLE.
- Request outputs are registered from the state and stable for the whole transaction.
- Core inputs that change mid-miss are unsupported. The FSM latches index, tag and victim on leaving IDLE and uses the latched values.
- Reset mid-WB or mid-FILL: return to IDLE immediately, drop req_to_arbiter that cycle, and discard the partial transaction.
- Multiple valid matches cannot occur by construction. If they did, the lowest-numbered way wins.

Decomposition:
- Package brisc_pkg gains:
  - the dcache_state_e enum (IDLE, WB, FILL);
  - DCACHE_NUM_SETS and DCACHE_NUM_WAYS defaults;
  - the function line_offset_bits(line_width).
  XLEN and BYTE_LEN come from the package.
- Sub-module dcache_way_array holds the tag, valid, dirty and data flops of one way. It has one write port (full-line fill, or word/byte update) and an asynchronous read of all sets. The top level instantiates NUM_WAYS copies and contains the FSM, hit/select logic and victim pointers.

Test Plan (defaults: OFF=4, IDX=2 using addr[5:4], tag=addr[31:6]; memory holds byte value = addr[7:0]):
1. Reset, then load word 0x104 → req_to_arbiter=1 and req_store_to_mem=0 with req_addr_to_mem=0x100. Grant after 3 cycles, fill pulse → next cycle hit=1, data_out=0x07060504.
2. Store word 0x104 data 0xDEADBEEF → hit=1 the same cycle with no req_to_arbiter. Then load byte 0x105 → data_out=0x000000BE; load word 0x108 → 0x0B0A0908.
3. Load 0x140 (set 0, way 1 fill) → only one FILL. Then load 0x180 → WB to 0x100 with req_line_to_mem[63:32]=0xDEADBEEF, then FILL 0x180, then hit with data_out=0x83828180.
4. Load 0x100 again → the victim is 0x140 (clean) → FILL only, with no WB.
5. Assert rst_n=0 during FILL before the fill pulse → req_to_arbiter=0 immediately. Reloading 0x104 misses again.
6. Pulse fill_data_from_mem_valid with arbiter_grant=0 during FILL, or in IDLE → no state change and no array write.
